// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding
// and frame constants.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value.
// Ports:
//   clk   - sampling clock
//   reset - synchronous active-high reset, loads RESET_VAL into both flops
//   d_i   - asynchronous input
//   q_o   - synchronised output, two cycles behind d_i
module sync_2ff #(
   parameter int unsigned           WIDTH     = 1,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ascii.sv
// UART receiver feeding the unlock sequence detector. Deserialises 8N1
// frames (8E1 when UART_RX_PARITY_EN is defined) and presents each good
// character on ascii_out for exactly one cycle; the bus rests at 8'h00.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   rx         - asynchronous serial line, idles high
//   ascii_out  - received byte while valid is high, 8'h00 otherwise
//   valid      - one-cycle strobe for a good frame
//   parity_err - one-cycle strobe for bad even parity (UART_RX_PARITY_EN only)
//   frame_err  - one-cycle strobe when the stop bit samples low
module uart_rx_ascii
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] ascii_out,
   output logic                      valid,
`ifdef UART_RX_PARITY_EN
   output logic                      parity_err,
`endif
   output logic                      frame_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_cpb
      $error("CLKS_PER_BIT must be even and at least 4");
   end

   logic                      rx_s;
   uart_state_e               state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [IDX_W-1:0]          bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
   logic                      parity_bad_q;
`endif

   // Line resets to idle level so a reset never fakes a start bit.
   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // Receive FSM; strobes default low and are raised only on the stop sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         ascii_out    <= '0;
         valid        <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_q <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         ascii_out <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= '0;
               if (rx_s != UART_IDLE_LEVEL) begin
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q   <= '0;
                  // A start bit that has vanished by mid-bit is a glitch.
                  state_q <= (rx_s == UART_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q        <= '0;
                  // Even parity: data plus parity bit must XOR to zero.
                  parity_bad_q <= ^{shift_q, rx_s};
                  state_q      <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            ST_STOP: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q <= '0;
                  if (rx_s == UART_IDLE_LEVEL) begin
                     state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (parity_bad_q) begin
                        parity_err <= 1'b1;
                     end else begin
                        valid     <= 1'b1;
                        ascii_out <= shift_q;
                     end
`else
                     valid     <= 1'b1;
                     ascii_out <= shift_q;
`endif
                  end else begin
                     frame_err <= 1'b1;
                     state_q   <= ST_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_BREAK: begin
               // Line held low: wait for idle before looking for a new start.
               if (rx_s == UART_IDLE_LEVEL) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
